pcm_line_encoder: RTL and testbench
===================================

PCM_LINE_ENCODER -- requirements
Module: pcm_line_encoder

Interface
REQ-001 SHALL provide parameter LFSR_W, default 15, randomizer register width (3..32).
REQ-002 SHALL provide parameter TAP_A, default 14, first feedback bit index (< LFSR_W).
REQ-003 SHALL provide parameter TAP_B, default 13, second feedback bit index (< LFSR_W, != TAP_A).
REQ-004 SHALL provide parameter SEED, default 0, LFSR_W-bit value loaded at reset and at frame sync.
REQ-005 SHALL provide port clk_temp input 1, encoder clock; equals the bit clock for NRZ codes and 2x the bit clock for bi-phase codes.
REQ-006 SHALL provide port rst_n_i input 1, reset, asynchronous, active-low.
REQ-007 SHALL provide port pattern_i input 3, code select: 0 RNRZ-L, 1 NRZ-L, 2 NRZ-M, 3 NRZ-S, 4 Biph-L, 5 Biph-M, 6 Biph-S, 7 reserved (acts as NRZ-L).
REQ-008 SHALL provide port bit_stb_i input 1, one-cycle strobe; data_i is valid in that cycle.
REQ-009 SHALL provide port data_i input 1, source bit.
REQ-010 SHALL provide port frame_sync_i input 1, frame start qualifier; sampled only with bit_stb_i.
REQ-011 SHALL provide port data_o output 1, line-coded output.
REQ-012 SHALL provide port lfsr_o output LFSR_W, current randomizer state.
REQ-013 SHALL provide port err_o output 1, sticky strobe-protocol error.

Function
REQ-014 All state SHALL update on rising clk_temp; cycles without bit_stb_i SHALL hold data_o, LFSR and pattern, except the bi-phase second half (REQ-021).
REQ-015 Active pattern SHALL be a register, reset to 1 (NRZ-L), loaded from pattern_i only on a cycle with bit_stb_i=1 and frame_sync_i=1; that same bit SHALL be coded in the new pattern.
REQ-016 On every accepted strobe the randomizer SHALL compute t = data_i ^ r[TAP_A] ^ r[TAP_B] and shift r <= {r[LFSR_W-2:0], t}, in every pattern.
REQ-017 If frame_sync_i=1 on the strobe, t and the shift SHALL use SEED in place of r (reload and advance in one cycle).
REQ-018 Data SHALL be registered: data_o changes the cycle after the strobe (1-cycle latency).
REQ-019 NRZ codes: RNRZ-L data_o <= t; NRZ-L data_o <= data_i; NRZ-M data_o <= data_o ^ data_i; NRZ-S data_o <= data_o XNOR data_i.
REQ-020 Bi-phase FSM SHALL have states IDLE, HALF1, HALF2; accepted strobe from IDLE or HALF2 goes to HALF1; HALF1 goes unconditionally to HALF2; HALF2 without strobe goes to IDLE.
REQ-021 Bi-phase output on entering HALF1/HALF2: Biph-L data_i then ~data_i; Biph-M ~data_o then (toggle if bit=1); Biph-S ~data_o then (toggle if bit=0); the bit is held internally for HALF2.
REQ-022 A strobe arriving while the FSM is in HALF1 (i.e. about to enter HALF2) SHALL be ignored entirely (no LFSR, pattern or data update) and SHALL set err_o.
REQ-023 err_o SHALL remain 1 until reset; NRZ patterns SHALL never set it.
REQ-024 A pattern change between NRZ and bi-phase SHALL take effect only per REQ-015; FSM SHALL be in IDLE whenever active pattern is NRZ.

Reset
REQ-025 rst_n_i low SHALL immediately force data_o=0, lfsr_o=SEED, err_o=0, active pattern=1, FSM=IDLE, held bit=0.
REQ-026 Reset mid-bit (HALF1/HALF2) SHALL abandon the bit; first strobe after release is coded as the first bit from reset state.

Configuration
REQ-027 Macro PCM_BIPHASE_EN defined SHALL compile in the bi-phase FSM and patterns 4-6 per REQ-020..REQ-023.
REQ-028 Without PCM_BIPHASE_EN patterns 4-6 SHALL behave as NRZ-L, no FSM logic SHALL exist, and err_o SHALL be tied 0.

Verification
REQ-029 Defaults, pattern 0 loaded with sync, data_i=1 on 15 strobes -> data_o bits 1 x14 then 0; lfsr_o after 14 strobes = 0x3FFF.
REQ-030 Pattern 2, data_o=0, data 1,0,1,1 -> data_o 1,1,0,1; pattern 3 same data from 0 -> 0,1,1,1.
REQ-031 PCM_BIPHASE_EN, pattern 4, strobes every 2 cycles, data 1,0 -> data_o per cycle 1,0,0,1; pattern 5 data 1,0 from 0 -> 1,0,1,1.
REQ-032 Pattern 4, strobes on two consecutive cycles -> second ignored, err_o=1, lfsr_o advanced once; err_o stays 1 until rst_n_i low.
REQ-033 rst_n_i pulsed low during HALF1 -> data_o=0, lfsr_o=SEED, err_o=0 asynchronously; next strobe data 1 in NRZ-L -> data_o=1 one cycle later.
REQ-034 pattern_i changed to 2 with frame_sync_i=0 -> no effect; next strobe with frame_sync_i=1 -> NRZ-M from that bit, lfsr_o = {SEED[13:0], t}.

Source files
------------

// File: rtl/pcm_line_encoder.sv
// PCM line encoder: NRZ family with serial randomizer; bi-phase codes (Biph-L/M/S)
// are compiled in only when the macro PCM_BIPHASE_EN is defined.
module pcm_line_encoder #(
    parameter int unsigned        LFSR_W = 15,
    parameter int unsigned        TAP_A  = 14,
    parameter int unsigned        TAP_B  = 13,
    parameter logic [LFSR_W-1:0]  SEED   = '0
) (
    input  logic              clk_temp,
    input  logic              rst_n_i,
    input  logic [2:0]        pattern_i,
    input  logic              bit_stb_i,
    input  logic              data_i,
    input  logic              frame_sync_i,
    output logic              data_o,
    output logic [LFSR_W-1:0] lfsr_o,
    output logic              err_o
);

    localparam logic [2:0] PAT_RNRZ_L = 3'd0;
    localparam logic [2:0] PAT_NRZ_L  = 3'd1;
    localparam logic [2:0] PAT_NRZ_M  = 3'd2;
    localparam logic [2:0] PAT_NRZ_S  = 3'd3;

    logic [2:0]        pattern_q, pattern_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic              data_q, data_d;

    logic [2:0]        pat_sel;
    logic [LFSR_W-1:0] lfsr_base;
    logic              fb;
    logic              nrz_bit;

`ifdef PCM_BIPHASE_EN
    localparam logic [2:0] PAT_BIPH_L = 3'd4;
    localparam logic [2:0] PAT_BIPH_M = 3'd5;
    localparam logic [2:0] PAT_BIPH_S = 3'd6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HALF1 = 2'd1,
        HALF2 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   bit_q, bit_d;
    logic   err_q, err_d;
`endif

    always_comb begin
        pattern_d = pattern_q;
        lfsr_d    = lfsr_q;
        data_d    = data_q;
        // A frame-sync strobe switches code and reseeds in the same cycle.
        pat_sel   = frame_sync_i ? pattern_i : pattern_q;
        lfsr_base = frame_sync_i ? SEED : lfsr_q;
        fb        = data_i ^ lfsr_base[TAP_A] ^ lfsr_base[TAP_B];
        case (pat_sel)
            PAT_RNRZ_L: nrz_bit = fb;
            PAT_NRZ_M:  nrz_bit = data_q ^ data_i;
            PAT_NRZ_S:  nrz_bit = ~(data_q ^ data_i);
            default:    nrz_bit = data_i;
        endcase
`ifdef PCM_BIPHASE_EN
        state_d = state_q;
        bit_d   = bit_q;
        err_d   = err_q;
        if (state_q == HALF1) begin
            // Second half of a bi-phase bit; a strobe here is a protocol error and is dropped.
            state_d = HALF2;
            if (bit_stb_i) begin
                err_d = 1'b1;
            end
            case (pattern_q)
                PAT_BIPH_L: data_d = ~bit_q;
                PAT_BIPH_M: data_d = data_q ^ bit_q;
                default:    data_d = ~(data_q ^ bit_q);
            endcase
        end else if (bit_stb_i) begin
            pattern_d = pat_sel;
            lfsr_d    = {lfsr_base[LFSR_W-2:0], fb};
            if (pat_sel == PAT_BIPH_L || pat_sel == PAT_BIPH_M || pat_sel == PAT_BIPH_S) begin
                state_d = HALF1;
                bit_d   = data_i;
                data_d  = (pat_sel == PAT_BIPH_L) ? data_i : ~data_q;
            end else begin
                state_d = IDLE;
                data_d  = nrz_bit;
            end
        end else if (state_q == HALF2) begin
            state_d = IDLE;
        end
`else
        if (bit_stb_i) begin
            pattern_d = pat_sel;
            lfsr_d    = {lfsr_base[LFSR_W-2:0], fb};
            data_d    = nrz_bit;
        end
`endif
    end

    always_ff @(posedge clk_temp or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pattern_q <= PAT_NRZ_L;
            lfsr_q    <= SEED;
            data_q    <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            lfsr_q    <= lfsr_d;
            data_q    <= data_d;
        end
    end

`ifdef PCM_BIPHASE_EN
    always_ff @(posedge clk_temp or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            bit_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            err_q   <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign data_o = data_q;
    assign lfsr_o = lfsr_q;

endmodule

// File: tb/tb_pcm_line_encoder.sv
// Directed bench for pcm_line_encoder: NRZ vector table plus bi-phase and reset sequences
// (bi-phase sequences exercised when PCM_BIPHASE_EN is defined).
module tb_pcm_line_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  pattern;
    logic        stb;
    logic        din;
    logic        sync;
    logic        dout;
    logic [14:0] lfsr;
    logic        err;

    int total = 0;
    int bad   = 0;

    pcm_line_encoder dut (
        .clk_temp     (clk),
        .rst_n_i      (rst_n),
        .pattern_i    (pattern),
        .bit_stb_i    (stb),
        .data_i       (din),
        .frame_sync_i (sync),
        .data_o       (dout),
        .lfsr_o       (lfsr),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stb;
        logic        sync;
        logic [2:0]  pat;
        logic        din;
        logic        exp_d;
        logic [14:0] exp_l;
    } vec_t;

    vec_t tbl[40];
    int   nv = 0;

    task automatic add(input logic s, input logic fs, input logic [2:0] p, input logic d,
                       input logic ed, input logic [14:0] el);
        tbl[nv] = '{stb: s, sync: fs, pat: p, din: d, exp_d: ed, exp_l: el};
        nv++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply inputs for one cycle, then sample 1 time unit after the rising edge.
    task automatic cyc(input logic s, input logic fs, input logic [2:0] p, input logic d);
        stb = s; sync = fs; pattern = p; din = d;
        @(posedge clk);
        #1;
        $display("cyc stb=%0b sync=%0b pat=%0d din=%0b -> data_o=%0b lfsr_o=%04h err_o=%0b",
                 s, fs, p, d, dout, lfsr, err);
    endtask

    task automatic do_reset();
        stb = 1'b0; sync = 1'b0; pattern = 3'd1; din = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Randomized NRZ-L from seed 0 with all-ones data: 14 ones then a zero.
        add(1, 1, 3'd0, 1, 1, 15'h0001);
        add(1, 0, 3'd0, 1, 1, 15'h0003);
        add(1, 0, 3'd0, 1, 1, 15'h0007);
        add(1, 0, 3'd0, 1, 1, 15'h000F);
        add(1, 0, 3'd0, 1, 1, 15'h001F);
        add(1, 0, 3'd0, 1, 1, 15'h003F);
        add(1, 0, 3'd0, 1, 1, 15'h007F);
        add(1, 0, 3'd0, 1, 1, 15'h00FF);
        add(1, 0, 3'd0, 1, 1, 15'h01FF);
        add(1, 0, 3'd0, 1, 1, 15'h03FF);
        add(1, 0, 3'd0, 1, 1, 15'h07FF);
        add(1, 0, 3'd0, 1, 1, 15'h0FFF);
        add(1, 0, 3'd0, 1, 1, 15'h1FFF);
        add(1, 0, 3'd0, 1, 1, 15'h3FFF);
        add(1, 0, 3'd0, 1, 0, 15'h7FFE);
        add(0, 0, 3'd0, 0, 0, 15'h7FFE);   // no strobe: hold
        // NRZ-M from data_o=0: data 1,0,1,1 -> 1,1,0,1
        add(1, 1, 3'd1, 0, 0, 15'h0000);
        add(1, 1, 3'd2, 1, 1, 15'h0001);
        add(1, 0, 3'd2, 0, 1, 15'h0002);
        add(1, 0, 3'd2, 1, 0, 15'h0005);
        add(1, 0, 3'd2, 1, 1, 15'h000B);
        add(0, 0, 3'd2, 0, 1, 15'h000B);
        // NRZ-S from data_o=0: data 1,0,1,1 -> 0,1,1,1
        add(1, 1, 3'd1, 0, 0, 15'h0000);
        add(1, 1, 3'd3, 1, 0, 15'h0001);
        add(1, 0, 3'd3, 0, 1, 15'h0002);
        add(1, 0, 3'd3, 1, 1, 15'h0005);
        add(1, 0, 3'd3, 1, 1, 15'h000B);
        // Reserved code acts as NRZ-L
        add(1, 1, 3'd7, 1, 1, 15'h0001);
        add(1, 0, 3'd7, 0, 0, 15'h0002);
        // pattern_i change without frame sync ignored, then taken with sync
        add(1, 0, 3'd2, 1, 1, 15'h0005);
        add(1, 1, 3'd2, 1, 0, 15'h0001);

        do_reset();
        chk("reset_data", {31'd0, dout}, 32'd0);
        chk("reset_lfsr", {17'd0, lfsr}, 32'd0);
        chk("reset_err",  {31'd0, err},  32'd0);

        for (int i = 0; i < nv; i++) begin
            cyc(tbl[i].stb, tbl[i].sync, tbl[i].pat, tbl[i].din);
            chk($sformatf("vec%0d_data", i), {31'd0, dout}, {31'd0, tbl[i].exp_d});
            chk($sformatf("vec%0d_lfsr", i), {17'd0, lfsr}, {17'd0, tbl[i].exp_l});
        end
        chk("nrz_err", {31'd0, err}, 32'd0);

`ifdef PCM_BIPHASE_EN
        // Biph-L, strobe every 2 cycles, data 1,0 -> 1,0,0,1
        do_reset();
        cyc(1, 1, 3'd4, 1); chk("bl_c0", {31'd0, dout}, 32'd1);
        cyc(0, 0, 3'd4, 0); chk("bl_c1", {31'd0, dout}, 32'd0);
        cyc(1, 0, 3'd4, 0); chk("bl_c2", {31'd0, dout}, 32'd0);
        cyc(0, 0, 3'd4, 0); chk("bl_c3", {31'd0, dout}, 32'd1);
        cyc(0, 0, 3'd4, 0); chk("bl_hold", {31'd0, dout}, 32'd1);
        chk("bl_lfsr", {17'd0, lfsr}, 32'h0002);
        // Biph-M from 0, data 1,0 -> 1,0,1,1
        cyc(1, 1, 3'd1, 0); chk("bm_pre", {31'd0, dout}, 32'd0);
        cyc(1, 1, 3'd5, 1); chk("bm_c0", {31'd0, dout}, 32'd1);
        cyc(0, 0, 3'd5, 0); chk("bm_c1", {31'd0, dout}, 32'd0);
        cyc(1, 0, 3'd5, 0); chk("bm_c2", {31'd0, dout}, 32'd1);
        cyc(0, 0, 3'd5, 0); chk("bm_c3", {31'd0, dout}, 32'd1);
        // Biph-S from 0, data 1,0 -> 1,1,0,1
        cyc(1, 1, 3'd1, 0); chk("bs_pre", {31'd0, dout}, 32'd0);
        cyc(1, 1, 3'd6, 1); chk("bs_c0", {31'd0, dout}, 32'd1);
        cyc(0, 0, 3'd6, 0); chk("bs_c1", {31'd0, dout}, 32'd1);
        cyc(1, 0, 3'd6, 0); chk("bs_c2", {31'd0, dout}, 32'd0);
        cyc(0, 0, 3'd6, 0); chk("bs_c3", {31'd0, dout}, 32'd1);
        chk("bs_err", {31'd0, err}, 32'd0);
        // Strobe during HALF1: dropped, err set and sticky
        do_reset();
        cyc(1, 1, 3'd4, 1); chk("e_c0", {31'd0, dout}, 32'd1);
        cyc(1, 0, 3'd4, 0); chk("e_c1", {31'd0, dout}, 32'd0);
        chk("e_err", {31'd0, err}, 32'd1);
        chk("e_lfsr", {17'd0, lfsr}, 32'h0001);
        cyc(0, 0, 3'd4, 0); chk("e_err_hold", {31'd0, err}, 32'd1);
        cyc(1, 0, 3'd4, 1); chk("e_next", {31'd0, dout}, 32'd1);
        chk("e_next_lfsr", {17'd0, lfsr}, 32'h0003);
        chk("e_err_sticky", {31'd0, err}, 32'd1);
        // Async reset in HALF1 abandons the bit
        cyc(0, 0, 3'd4, 0);
        cyc(1, 0, 3'd4, 1); chk("r_half1", {31'd0, dout}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("r_data", {31'd0, dout}, 32'd0);
        chk("r_lfsr", {17'd0, lfsr}, 32'd0);
        chk("r_err",  {31'd0, err},  32'd0);
        #1 rst_n = 1'b1;
        cyc(1, 0, 3'd4, 1); chk("r_first", {31'd0, dout}, 32'd1);
        chk("r_first_lfsr", {17'd0, lfsr}, 32'h0001);
        cyc(0, 0, 3'd4, 0); chk("r_nrz_hold", {31'd0, dout}, 32'd1);
`else
        // Bi-phase codes absent: pattern 4 codes as NRZ-L, err never set
        do_reset();
        cyc(1, 1, 3'd4, 1); chk("p4_c0", {31'd0, dout}, 32'd1);
        cyc(1, 0, 3'd4, 0); chk("p4_c1", {31'd0, dout}, 32'd0);
        chk("p4_lfsr", {17'd0, lfsr}, 32'h0002);
        chk("p4_err", {31'd0, err}, 32'd0);
        cyc(1, 0, 3'd4, 1); chk("r_pre", {31'd0, dout}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("r_data", {31'd0, dout}, 32'd0);
        chk("r_lfsr", {17'd0, lfsr}, 32'd0);
        #1 rst_n = 1'b1;
        cyc(1, 0, 3'd4, 1); chk("r_first", {31'd0, dout}, 32'd1);
        chk("r_first_lfsr", {17'd0, lfsr}, 32'h0001);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
